// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch sequencer: FSM state encoding,
// buffer entry layout and instruction size.
package fetch_pkg;

  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [63:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {inst, pc} entries. Flush wins over
// push/pop; a push into a full buffer is accepted only when a pop frees a slot.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked by the top whenever count is 0.
  always_ff @(posedge clk) begin
    if (reset && !flush && do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/inst_fetch_sequencer.sv
// Fetch controller: owns the PC, fetches from instruction memory into a
// prefetch buffer and hands words to decode. Optional misaligned-PC trap
// is enabled by defining FETCH_MISALIGN_CHECK_EN.
module inst_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          MEM_BYTES = 16,
  parameter int          BUF_DEPTH = 2,
  parameter logic [63:0] RESET_PC  = 64'd0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Start,
  input  logic [63:0]  Boot_Address,
  output logic [61:0]  Inst_Address,
  input  logic [31:0]  Instruction,
  input  logic         Branch_Taken,
  input  logic [63:0]  Branch_Target,
  input  logic         Stall,
  output logic [31:0]  Inst_Out,
  output logic [63:0]  Inst_PC,
  output logic         Inst_Valid,
  input  logic         Inst_Ready,
  output logic         Halted,
  output logic         Fetch_Fault,
  output fetch_state_t dbg_state
);

  localparam int          CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam logic [63:0] LAST_PC = 64'(MEM_BYTES - INST_BYTES);

  fetch_state_t     state;
  logic [63:0]      pc;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  logic             buf_full;
  logic             pop;
  logic             past_end;
  logic             start_go;
  logic             redirect;
  logic             push_ok;
  fetch_state_t     entry_state;

  // Handshake: a head transfer happens on a rising edge where Inst_Valid and
  // Inst_Ready are both high; Inst_Valid never waits on Inst_Ready.
  assign Inst_Valid = (count != '0);
  assign buf_full   = (count == CNT_W'(BUF_DEPTH));
  assign pop        = Inst_Valid && Inst_Ready;
  assign past_end   = pc > LAST_PC;
  assign start_go   = (state == S_IDLE) && Start;
  assign redirect   = Branch_Taken && ((state == S_FETCH) || (state == S_HALT));
  assign push_ok    = (state == S_FETCH) && !Branch_Taken && !Stall && !past_end
                      && (!buf_full || pop);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic [63:0] entry_addr;
  assign entry_addr  = start_go ? Boot_Address : Branch_Target;
  assign entry_state = is_misaligned(entry_addr) ? S_FAULT : S_FETCH;
  assign Fetch_Fault = (state == S_FAULT);
`else
  assign entry_state = S_FETCH;
  assign Fetch_Fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            pc    <= Boot_Address;
            state <= entry_state;
          end
        end
        S_FETCH, S_HALT: begin
          if (Branch_Taken) begin
            pc    <= Branch_Target;
            state <= entry_state;
          end else if (state == S_FETCH) begin
            if (past_end)     state <= S_HALT;
            else if (push_ok) pc    <= pc + 64'(INST_BYTES);
          end
        end
        default: state <= state;
      endcase
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_buffer (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect || start_go),
    .push       (push_ok),
    .push_entry ('{inst: Instruction, pc: pc}),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  assign Inst_Address = pc[61:0];
  assign Inst_Out     = Inst_Valid ? head.inst : 32'd0;
  assign Inst_PC      = Inst_Valid ? head.pc   : 64'd0;
  assign Halted       = (state == S_HALT) && !Inst_Valid;
  assign dbg_state    = state;

endmodule

// File: tb/tb_inst_fetch_sequencer.sv
// Directed bench for inst_fetch_sequencer with a 16-byte little-endian
// instruction memory model; covers FETCH_MISALIGN_CHECK_EN both ways.
module tb_inst_fetch_sequencer;
  import fetch_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         Start;
  logic [63:0]  Boot_Address;
  logic [61:0]  Inst_Address;
  logic [31:0]  Instruction;
  logic         Branch_Taken;
  logic [63:0]  Branch_Target;
  logic         Stall;
  logic [31:0]  Inst_Out;
  logic [63:0]  Inst_PC;
  logic         Inst_Valid;
  logic         Inst_Ready;
  logic         Halted;
  logic         Fetch_Fault;
  fetch_state_t dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [31:0] W0 = 32'h0F053483;
  localparam logic [31:0] W1 = 32'h00A00513;
  localparam logic [31:0] W2 = 32'h00B00593;
  localparam logic [31:0] W3 = 32'h00C58633;

  logic [7:0] mem_b [16];

  inst_fetch_sequencer #(
    .MEM_BYTES (16),
    .BUF_DEPTH (2),
    .RESET_PC  (64'd0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Start         (Start),
    .Boot_Address  (Boot_Address),
    .Inst_Address  (Inst_Address),
    .Instruction   (Instruction),
    .Branch_Taken  (Branch_Taken),
    .Branch_Target (Branch_Target),
    .Stall         (Stall),
    .Inst_Out      (Inst_Out),
    .Inst_PC       (Inst_PC),
    .Inst_Valid    (Inst_Valid),
    .Inst_Ready    (Inst_Ready),
    .Halted        (Halted),
    .Fetch_Fault   (Fetch_Fault),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // combinational memory model, bytes outside 0..15 read as zero
  function automatic logic [7:0] rd_byte(input logic [61:0] a);
    return (a < 62'd16) ? mem_b[a[3:0]] : 8'h00;
  endfunction

  always_comb begin
    Instruction = {rd_byte(Inst_Address + 62'd3), rd_byte(Inst_Address + 62'd2),
                   rd_byte(Inst_Address + 62'd1), rd_byte(Inst_Address)};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic check_head(input string tag, input logic [63:0] pc, input logic [31:0] inst);
    check({tag, "_valid"}, 64'(Inst_Valid), 64'd1);
    check({tag, "_pc"}, Inst_PC, pc);
    check({tag, "_inst"}, 64'(Inst_Out), 64'(inst));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      case (i)
        0:       w = W0;
        1:       w = W1;
        2:       w = W2;
        default: w = W3;
      endcase
      for (int b = 0; b < 4; b++) mem_b[i*4 + b] = w[b*8 +: 8];
    end

    reset = 1'b0; Start = 1'b0; Boot_Address = 64'd0; Branch_Taken = 1'b0;
    Branch_Target = 64'd0; Stall = 1'b0; Inst_Ready = 1'b0;
    @(negedge clk);
    do_reset();

    // reset values
    check("rst_valid", 64'(Inst_Valid), 64'd0);
    check("rst_out", 64'(Inst_Out), 64'd0);
    check("rst_pc", Inst_PC, 64'd0);
    check("rst_halted", 64'(Halted), 64'd0);
    check("rst_fault", 64'(Fetch_Fault), 64'd0);
    check("rst_addr", 64'(Inst_Address), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));

    // branch ignored in IDLE
    Branch_Taken = 1'b1; Branch_Target = 64'd8;
    tick();
    Branch_Taken = 1'b0;
    check("idle_br_state", 64'(dbg_state), 64'(S_IDLE));
    check("idle_br_addr", 64'(Inst_Address), 64'd0);

    // streaming run with Inst_Ready held high
    Inst_Ready = 1'b1; Start = 1'b1; Boot_Address = 64'd0;
    tick();
    Start = 1'b0;
    check("start_state", 64'(dbg_state), 64'(S_FETCH));
    check("start_valid", 64'(Inst_Valid), 64'd0);
    tick(); check_head("s0", 64'd0, W0);
    tick(); check_head("s4", 64'd4, W1);
    tick(); check_head("s8", 64'd8, W2);
    tick(); check_head("s12", 64'd12, W3);
    tick();
    check("s_end_valid", 64'(Inst_Valid), 64'd0);
    check("s_end_state", 64'(dbg_state), 64'(S_HALT));
    check("s_end_halted", 64'(Halted), 64'd1);

    // backpressure: buffer fills to depth, PC holds at 8
    do_reset();
    Inst_Ready = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick(); tick(); tick(); tick();
    check("bp_addr", 64'(Inst_Address), 64'd8);
    check_head("bp_head", 64'd0, W0);
    Inst_Ready = 1'b1;
    tick(); check_head("bp4", 64'd4, W1);
    tick(); check_head("bp8", 64'd8, W2);
    tick(); check_head("bp12", 64'd12, W3);
    check("bp12_halted", 64'(Halted), 64'd0);
    tick();
    check("bp_end_valid", 64'(Inst_Valid), 64'd0);
    check("bp_end_halted", 64'(Halted), 64'd1);

    // redirect to 4 while full; the pop in the redirect cycle is discarded
    do_reset();
    Inst_Ready = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick(); tick();
    check("br_full_addr", 64'(Inst_Address), 64'd8);
    Inst_Ready = 1'b1; Branch_Taken = 1'b1; Branch_Target = 64'd4;
    tick();
    Branch_Taken = 1'b0;
    check("br_valid_low", 64'(Inst_Valid), 64'd0);
    check("br_addr", 64'(Inst_Address), 64'd4);
    tick(); check_head("br4", 64'd4, W1);
    tick(); check_head("br8", 64'd8, W2);

    // stall for 3 cycles: PC frozen at 12, head held
    Inst_Ready = 1'b0; Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", 64'(Inst_Address), 64'd12);
      check("stall_pc", Inst_PC, 64'd8);
    end
    Stall = 1'b0;
    tick();
    check("unstall_addr", 64'(Inst_Address), 64'd16);
    Inst_Ready = 1'b1;
    tick(); check_head("unstall12", 64'd12, W3);
    tick();
    check("unstall_halted", 64'(Halted), 64'd1);

    // branch out of HALT to 8
    Branch_Taken = 1'b1; Branch_Target = 64'd8;
    tick();
    Branch_Taken = 1'b0;
    check("hbr_state", 64'(dbg_state), 64'(S_FETCH));
    check("hbr_halted", 64'(Halted), 64'd0);
    tick(); check_head("hbr8", 64'd8, W2);
    tick(); check_head("hbr12", 64'd12, W3);
    tick();
    check("hbr_end_halted", 64'(Halted), 64'd1);

    // misaligned redirect to 6
    Branch_Taken = 1'b1; Branch_Target = 64'd6;
    tick();
    Branch_Taken = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_fault", 64'(Fetch_Fault), 64'd1);
    check("mis_valid", 64'(Inst_Valid), 64'd0);
    check("mis_state", 64'(dbg_state), 64'(S_FAULT));
    tick();
    check("mis_nofetch", 64'(Inst_Valid), 64'd0);
    Branch_Taken = 1'b1; Branch_Target = 64'd0;
    tick();
    Branch_Taken = 1'b0;
    check("mis_sticky", 64'(Fetch_Fault), 64'd1);
    do_reset();
    check("mis_cleared", 64'(Fetch_Fault), 64'd0);
    check("mis_rst_state", 64'(dbg_state), 64'(S_IDLE));
`else
    check("mis_fault", 64'(Fetch_Fault), 64'd0);
    check("mis_state", 64'(dbg_state), 64'(S_FETCH));
    tick(); check_head("mis6", 64'd6, 32'h059300A0);
    check("mis_fault2", 64'(Fetch_Fault), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_fetch_sequencer.md
# inst_fetch_sequencer

Fetch controller for the byte-addressed instruction memory: owns the program counter, drives `Inst_Address`, captures the returned 32-bit `Instruction` into a small prefetch buffer, and presents fetched words to decode over a valid/ready handshake. It handles branch redirects, decode stalls and end-of-memory halting. It sits between `Instruction_Memory` and the decode stage.

## Interface
- `MEM_BYTES`, 16: instruction memory size in bytes.
- `BUF_DEPTH`, 2: prefetch buffer entries, 1..4.
- `RESET_PC`, 64'd0: PC loaded at reset.
- `clk` input 1: sole clock; everything updates on the rising edge.
- `reset` input 1: synchronous, active-low; sampled on the `clk` rising edge.
- `Start` input 1: in IDLE, loads `Boot_Address` into the PC and begins fetching.
- `Boot_Address` input 64: initial PC.
- `Inst_Address` output 62: PC[61:0], driven to memory combinationally from the PC register.
- `Instruction` input 32: memory read data, combinational from `Inst_Address`.
- `Branch_Taken` input 1: redirect request.
- `Branch_Target` input 64: redirect PC.
- `Stall` input 1: suppresses the fetch push this cycle.
- `Inst_Out` output 32: buffer head instruction.
- `Inst_PC` output 64: buffer head PC.
- `Inst_Valid` output 1: buffer non-empty.
- `Inst_Ready` input 1: decode accepts the head.
- `Halted` output 1: asserted when the state is HALT and the buffer is empty.
- `Fetch_Fault` output 1: misaligned PC trap. Present only under the macro; otherwise tied to 0.

## Operation
- States:
  - IDLE: wait for `Start`.
  - FETCH: normal fetching.
  - HALT: PC is past the end of memory.
  - FAULT: misaligned PC trap (macro only).
- Transitions:
  - IDLE → FETCH on `Start`; PC is set to `Boot_Address`.
  - FETCH → HALT when PC > `MEM_BYTES`−4. No push occurs that cycle.
  - Any of FETCH, HALT or FAULT → FETCH on `Branch_Taken`, with one exception: FAULT is left only by reset.
  - `Branch_Taken` is ignored in IDLE.
- Push in FETCH: `{Instruction, PC}` is written to the buffer and PC becomes PC+4 (64-bit, wraps modulo 2^64). A push requires all of:
  - no `Branch_Taken`,
  - no `Stall`,
  - PC ≤ `MEM_BYTES`−4,
  - the buffer not full, or full and popped this cycle.
- Pop: occurs when `Inst_Valid` and `Inst_Ready` are both high. Push and pop in the same cycle leave the count unchanged.
- Redirect:
  - `Branch_Taken` flushes the buffer (count becomes 0) and any pop in that cycle is discarded.
  - PC is set to `Branch_Target`.
  - No push occurs in the redirect cycle.
- Priority: `reset` > `Branch_Taken` > `Stall` > push.
- `Inst_Out` and `Inst_PC` are forced to 0 whenever `Inst_Valid` is 0.
- Reset values:
  - state IDLE, PC=`RESET_PC`, count 0.
  - `Inst_Valid`, `Inst_Out`, `Inst_PC`, `Halted` and `Fetch_Fault` all 0.
  - `Inst_Address` = `RESET_PC`[61:0].
- Reset asserted mid-operation discards buffer contents the same edge. No partial state survives.

## Timing
- `Start` sampled at edge N: at edge N+1 the first push occurs, so `Inst_Valid` is high after N+1. One-cycle start latency.
- Redirect at edge N: `Inst_Valid` is low after N. The target word is valid after N+1.
- Sustained throughput: one instruction per cycle while `Inst_Ready` is held high.
- `Halted` rises one cycle after the last entry pops in HALT.
- `Inst_Ready` must not combinationally depend on `Inst_Out`.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - If `Start` or `Branch_Taken` supplies an address with bits [1:0] ≠ 0, the buffer is flushed and the state becomes FAULT.
  - `Fetch_Fault` is high from the next cycle until reset.
  - No fetch occurs while in FAULT.
- Undefined: the low bits are used as-is and unaligned byte fetches proceed. There is no FAULT state and `Fetch_Fault` is constant 0.

## Structure
- `fetch_pkg` holds:
  - the state enum `fetch_state_t`,
  - `INST_BYTES`=4,
  - the buffer entry struct `{inst[31:0], pc[63:0]}`.
- Sub-module `fetch_buffer`: a `BUF_DEPTH`-entry synchronous FIFO with flush, simultaneous push/pop and count output. The sequencer holds the PC, FSM and push decision.

## Test plan
- Reset, then `Start` with `Boot_Address`=0 and `Inst_Ready`=1 → PCs 0, 4, 8, 12 are delivered on consecutive cycles with the word at 0 = 32'h0F053483. The state then goes to HALT and `Halted`=1 once the buffer drains.
- `Inst_Ready`=0 after `Start` → exactly `BUF_DEPTH` entries are buffered and PC holds at 8. Raising `Inst_Ready` → 0, 4, 8, 12 are delivered in order with no loss or duplicates.
- Branch in mid-stream to 4 while the buffer is full → the next valid has `Inst_PC`=4 one cycle later, and stale entries never appear.
- `Stall` held for 3 cycles in FETCH → no pushes and PC unchanged; fetching resumes on release.
- Branch to 8 from HALT → fetching restarts: 8, then 12, then HALT again.
- With the macro, branch to 6 → `Fetch_Fault`=1 next cycle and `Inst_Valid`=0. Only `reset` clears it.
